pipe_ctrl: RTL and testbench

PIPE_CTRL -- requirements
Module: pipe_ctrl

---
 rtl/pipe_ctrl.sv | 106 ++++++++++
 tb/tb_pipe_ctrl.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/pipe_ctrl.sv
// Pipeline hazard controller: per-stage stall vector, flush sequencing and stall counter.
// Optional sticky stall watchdog when PIPE_CTRL_STALL_WDOG_EN is defined.
module pipe_ctrl #(
   parameter logic [15:0] WDOG_LIMIT = 16'd1024
) (
   input  logic        clk_i,
   input  logic        rst_n_i,
   input  logic        stallreq_id_i,
   input  logic        stallreq_ex_i,
   input  logic        stallreq_mem_i,
   input  logic        flush_req_i,
   input  logic [31:0] flush_pc_i,
   output logic [5:0]  stall_o,
   output logic        flush_o,
   output logic [31:0] new_pc_o,
   output logic [15:0] stall_cnt_o,
   output logic        wdog_timeout_o
);

   typedef enum logic [1:0] {StRun, StPend, StFlush} state_e;

   state_e      state_q;
   logic        flush_q;
   logic [31:0] new_pc_q;
   logic [15:0] stall_cnt_q, stall_cnt_d;

   // A flush accepted in RUN this cycle kills the stall so the redirect is not held off.
   always_comb begin
      stall_o = 6'b000000;
      if (rst_n_i && state_q != StFlush &&
          !(state_q == StRun && flush_req_i && !stallreq_mem_i)) begin
         if (stallreq_mem_i)     stall_o = 6'b011111;
         else if (stallreq_ex_i) stall_o = 6'b001111;
         else if (stallreq_id_i) stall_o = 6'b000111;
         else                    stall_o = 6'b000000;
      end
   end

   always_comb begin
      stall_cnt_d = 16'h0000;
      if (stall_o != 6'b000000) begin
         stall_cnt_d = (stall_cnt_q == 16'hFFFF) ? stall_cnt_q : stall_cnt_q + 16'd1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q  <= StRun;
         flush_q  <= 1'b0;
         new_pc_q <= 32'h0;
      end else begin
         unique case (state_q)
            StRun: begin
               if (flush_req_i) begin
                  new_pc_q <= flush_pc_i;
                  state_q  <= stallreq_mem_i ? StPend : StFlush;
                  flush_q  <= !stallreq_mem_i;
               end else begin
                  flush_q  <= 1'b0;
               end
            end
            StPend: begin
               // First request wins; later requests and targets are dropped.
               if (!stallreq_mem_i) begin
                  state_q <= StFlush;
                  flush_q <= 1'b1;
               end
            end
            StFlush: begin
               state_q <= StRun;
               flush_q <= 1'b0;
            end
            default: begin
               state_q <= StRun;
               flush_q <= 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) stall_cnt_q <= 16'h0000;
      else          stall_cnt_q <= stall_cnt_d;
   end

`ifdef PIPE_CTRL_STALL_WDOG_EN
   logic wdog_q;

   // Updates on the same edge the counter reaches the limit, so both become visible together.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i)                        wdog_q <= 1'b0;
      else if (stall_cnt_d == WDOG_LIMIT)  wdog_q <= 1'b1;
   end

   assign wdog_timeout_o = wdog_q;
`else
   logic unused_wdog_limit;
   assign unused_wdog_limit = ^WDOG_LIMIT;
   assign wdog_timeout_o    = 1'b0;
`endif

   assign flush_o     = flush_q;
   assign new_pc_o    = new_pc_q;
   assign stall_cnt_o = stall_cnt_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: stimulus pushes per-cycle expectations, monitor pops at negedge.
// Watchdog expectations follow PIPE_CTRL_STALL_WDOG_EN.
module tb_pipe_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        id, ex, mem, fr;
   logic [31:0] pc;
   logic [5:0]  stall;
   logic        flush;
   logic [31:0] new_pc;
   logic [15:0] cnt;
   logic        wdog;

   int tests = 0;
   int fails = 0;
   bit stim_done = 1'b0;

`ifdef PIPE_CTRL_STALL_WDOG_EN
   localparam bit WdEn = 1'b1;
`else
   localparam bit WdEn = 1'b0;
`endif

   typedef struct {
      logic [5:0]  stall;
      logic        flush;
      logic [31:0] pc;
      logic [15:0] cnt;
      logic        wd;
      string       name;
   } exp_t;

   exp_t exp_q[$];

   always #5 clk = ~clk;

   pipe_ctrl #(.WDOG_LIMIT(16'd8)) dut (
      .clk_i          (clk),
      .rst_n_i        (rst_n),
      .stallreq_id_i  (id),
      .stallreq_ex_i  (ex),
      .stallreq_mem_i (mem),
      .flush_req_i    (fr),
      .flush_pc_i     (pc),
      .stall_o        (stall),
      .flush_o        (flush),
      .new_pc_o       (new_pc),
      .stall_cnt_o    (cnt),
      .wdog_timeout_o (wdog)
   );

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
      tests++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s: got %h expected %h", nm, act, req);
      end
   endtask

   // Monitor: the DUT presents a full output set every cycle; compare whenever one is expected.
   initial begin
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check({e.name, ".stall"}, {26'd0, stall}, {26'd0, e.stall});
            check({e.name, ".flush"}, {31'd0, flush}, {31'd0, e.flush});
            check({e.name, ".new_pc"}, new_pc, e.pc);
            check({e.name, ".cnt"}, {16'd0, cnt}, {16'd0, e.cnt});
            check({e.name, ".wdog"}, {31'd0, wdog}, {31'd0, e.wd & WdEn});
         end
      end
   end

   task automatic step(input logic rst_v, input logic i_id, input logic i_ex, input logic i_mem,
                       input logic i_fr, input logic [31:0] i_pc, input logic [5:0] es,
                       input logic ef, input logic [31:0] ep, input logic [15:0] ec,
                       input logic ew, input string nm);
      exp_t e;
      @(posedge clk);
      #1;
      rst_n = rst_v;
      id = i_id; ex = i_ex; mem = i_mem; fr = i_fr; pc = i_pc;
      e.stall = es; e.flush = ef; e.pc = ep; e.cnt = ec; e.wd = ew; e.name = nm;
      exp_q.push_back(e);
   endtask

   initial begin
      rst_n = 1'b0;
      id = 1'b0; ex = 1'b0; mem = 1'b0; fr = 1'b0; pc = 32'h0;
      repeat (2) @(posedge clk);
      //   rst id ex mem fr  pc            stall      fl pc            cnt  wd
      step(1, 0, 0, 0, 0, 32'h0,        6'b000000, 0, 32'h0,        0,  0, "reset_state");
      step(1, 1, 0, 0, 0, 32'h0,        6'b000111, 0, 32'h0,        0,  0, "id_only");
      step(1, 1, 0, 1, 0, 32'h0,        6'b011111, 0, 32'h0,        1,  0, "id_mem");
      step(1, 0, 0, 0, 0, 32'h0,        6'b000000, 0, 32'h0,        2,  0, "idle_a");
      step(1, 0, 0, 0, 0, 32'h0,        6'b000000, 0, 32'h0,        0,  0, "cnt_clear");
      step(1, 0, 0, 0, 1, 32'hBFC00380, 6'b000000, 0, 32'h0,        0,  0, "flush_req");
      step(1, 1, 0, 0, 1, 32'hDEADBEEF, 6'b000000, 1, 32'hBFC00380, 0,  0, "flush_state");
      step(1, 0, 0, 0, 0, 32'h0,        6'b000000, 0, 32'hBFC00380, 0,  0, "flush_done");
      step(1, 0, 0, 1, 1, 32'h00000100, 6'b011111, 0, 32'hBFC00380, 0,  0, "pend_enter");
      step(1, 0, 0, 1, 1, 32'h00000200, 6'b011111, 0, 32'h00000100, 1,  0, "pend_2nd_req");
      step(1, 0, 0, 1, 0, 32'h0,        6'b011111, 0, 32'h00000100, 2,  0, "pend_hold");
      step(1, 0, 0, 0, 0, 32'h0,        6'b000000, 0, 32'h00000100, 3,  0, "pend_release");
      step(1, 0, 0, 0, 0, 32'h0,        6'b000000, 1, 32'h00000100, 0,  0, "pend_flush");
      step(1, 0, 0, 0, 0, 32'h0,        6'b000000, 0, 32'h00000100, 0,  0, "pend_after");
      for (int k = 0; k < 5; k++)
         step(1, 0, 1, 0, 0, 32'h0,     6'b001111, 0, 32'h00000100, 16'(k), 0, "ex_stall");
      step(1, 0, 0, 0, 0, 32'h0,        6'b000000, 0, 32'h00000100, 5,  0, "ex_cnt5");
      step(1, 0, 0, 0, 0, 32'h0,        6'b000000, 0, 32'h00000100, 0,  0, "ex_cnt0");
      for (int k = 0; k < 10; k++)
         step(1, 0, 0, 1, 0, 32'h0,     6'b011111, 0, 32'h00000100, 16'(k), (k >= 8), "wdog_run");
      step(1, 0, 0, 0, 0, 32'h0,        6'b000000, 0, 32'h00000100, 10, 1, "wdog_sticky");
      step(1, 0, 0, 0, 0, 32'h0,        6'b000000, 0, 32'h00000100, 0,  1, "wdog_sticky2");
      step(1, 0, 0, 1, 1, 32'h00000300, 6'b011111, 0, 32'h00000100, 0,  1, "rst_pend_in");
      step(1, 0, 0, 1, 0, 32'h0,        6'b011111, 0, 32'h00000300, 1,  1, "rst_pend");
      // Reset asserted mid-cycle; the monitor samples before any further clock edge.
      step(0, 0, 0, 1, 0, 32'h0,        6'b000000, 0, 32'h0,        0,  0, "async_rst");
      step(1, 0, 0, 0, 0, 32'h0,        6'b000000, 0, 32'h0,        0,  0, "rst_release");
      step(1, 0, 0, 0, 0, 32'h0,        6'b000000, 0, 32'h0,        0,  0, "no_flush_pulse");
      stim_done = 1'b1;
   end

   initial begin
      wait (stim_done);
      repeat (3) @(posedge clk);
      check("queue_drained", exp_q.size(), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #20000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule
